// File: rtl/i281_pkg.sv
// Shared i281 definitions: BIOS image geometry and the boot loader state encoding.
package i281_pkg;
  localparam int BIOS_WORDS      = 32;
  localparam int BIOS_BANK_WORDS = 16;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_USER = 2'd3
  } state_t;
endpackage

// File: rtl/code_mem_boot_loader_if.sv
// Signal bundle between the code memory boot loader and its surroundings.
// Names carry the direction as seen from the loader (master modport).
interface code_mem_boot_loader_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
);
  logic              i_reload;
  logic [ADDR_W-1:0] o_bios_addr;
  logic [DATA_W-1:0] i_bios_word;
  // User write handshake: i_user_wr_req is the valid and stays high with stable
  // addr/data until o_user_wr_gnt pulses; the grant cycle is the write cycle itself.
  logic              i_user_wr_req;
  logic [ADDR_W-1:0] i_user_addr;
  logic [DATA_W-1:0] i_user_data;
  logic              o_user_wr_gnt;
  logic              o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [DATA_W-1:0] o_mem_data;
  logic              o_cpu_hold;
  logic              o_busy;
  logic              o_done;

  modport master (
    input  i_reload, i_bios_word, i_user_wr_req, i_user_addr, i_user_data,
    output o_bios_addr, o_user_wr_gnt, o_mem_we, o_mem_addr, o_mem_data,
           o_cpu_hold, o_busy, o_done
  );

  modport slave (
    output i_reload, i_bios_word, i_user_wr_req, i_user_addr, i_user_data,
    input  o_bios_addr, o_user_wr_gnt, o_mem_we, o_mem_addr, o_mem_data,
           o_cpu_hold, o_busy, o_done
  );
endinterface

// File: rtl/code_mem_boot_loader.sv
// Copies the BIOS image into code memory after reset, then arbitrates the code
// memory write port between BIOS reloads and single-word user writes.
module code_mem_boot_loader
  import i281_pkg::*;
#(
  parameter int WORDS  = BIOS_WORDS,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  code_mem_boot_loader_if.master bus,
  output state_t                 o_state
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(WORDS - 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] r_user_addr;
  logic [DATA_W-1:0] r_user_data;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_BOOT;
      r_cnt       <= '0;
      r_user_addr <= '0;
      r_user_data <= '0;
    end else begin
      case (r_state)
        ST_BOOT: r_state <= ST_LOAD;
        ST_LOAD: begin
          // A reload mid-copy restarts from word 0; the current write still lands.
          if (bus.i_reload) begin
            r_cnt <= '0;
          end else if (r_cnt == LAST) begin
            r_cnt   <= '0;
            r_state <= ST_RUN;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (bus.i_reload) begin
            r_cnt   <= '0;
            r_state <= ST_BOOT;
          end else if (bus.i_user_wr_req) begin
            r_user_addr <= bus.i_user_addr;
            r_user_data <= bus.i_user_data;
            r_state     <= ST_USER;
          end
        end
        ST_USER: r_state <= ST_RUN;
        default: r_state <= ST_BOOT;
      endcase
    end
  end

  logic w_load;
  logic w_user;
  assign w_load = (r_state == ST_LOAD);
  assign w_user = (r_state == ST_USER);

  always_comb begin
    bus.o_mem_addr = '0;
    bus.o_mem_data = '0;
    if (w_load) begin
      bus.o_mem_addr = r_cnt;
      bus.o_mem_data = bus.i_bios_word;
    end else if (w_user) begin
      bus.o_mem_addr = r_user_addr;
      bus.o_mem_data = r_user_data;
    end
  end

  assign bus.o_mem_we      = w_load | w_user;
  assign bus.o_user_wr_gnt = w_user;
  assign bus.o_done        = w_load & ~bus.i_reload & (r_cnt == LAST);
  assign bus.o_cpu_hold    = (r_state != ST_RUN);
  assign bus.o_busy        = (r_state == ST_BOOT) | w_load;
  assign bus.o_bios_addr   = r_cnt;
  assign o_state           = r_state;
endmodule

// File: tb/tb_code_mem_boot_loader.sv
// Directed bench for the code memory boot loader; the BIOS ROM returns 16'hA000 + index.
module tb_code_mem_boot_loader;
  import i281_pkg::*;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 5;
  localparam int WORDS  = 32;

  logic   clk = 1'b0;
  logic   rst = 1'b0;
  state_t state;
  int     n_vec = 0;
  int     n_err = 0;

  code_mem_boot_loader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  code_mem_boot_loader #(.WORDS(WORDS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .bus     (bus.master),
    .o_state (state)
  );

  always #5 clk = ~clk;

  assign bus.i_bios_word = 16'hA000 + {11'd0, bus.o_bios_addr};

  // Observed output vector: {we, addr, data, gnt, done, hold, busy}
  logic [25:0] obs;
  assign obs = {bus.o_mem_we, bus.o_mem_addr, bus.o_mem_data, bus.o_user_wr_gnt,
                bus.o_done, bus.o_cpu_hold, bus.o_busy};

  function automatic logic [25:0] pack(logic we, logic [4:0] a, logic [15:0] d,
                                       logic g, logic dn, logic h, logic b);
    return {we, a, d, g, dn, h, b};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_run(input string name);
    int n;
    n = 0;
    while (state != ST_RUN && n < 100) begin
      step();
      n++;
    end
    n_vec++;
    if (state !== ST_RUN) begin
      n_err++;
      $display("FAIL %s_wait_run: state=%0d after %0d cycles, required RUN", name, state, n);
    end
  endtask

  task automatic test_reset();
    logic [25:0] exp;
    bus.i_reload = 1'b0; bus.i_user_wr_req = 1'b0;
    bus.i_user_addr = '0; bus.i_user_data = '0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    exp = pack(1'b0, 5'd0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    n_vec++;
    if (obs !== exp) begin
      n_err++; $display("FAIL reset_outputs: obs=%h required=%h", obs, exp);
    end
    n_vec++;
    if (bus.o_bios_addr !== 5'd0 || state !== ST_BOOT) begin
      n_err++; $display("FAIL reset_state: bios_addr=%0d state=%0d required 0/BOOT", bus.o_bios_addr, state);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_boot_copy();
    logic [25:0] exp;
    exp = pack(1'b0, 5'd0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    n_vec++;
    if (obs !== exp || state !== ST_BOOT) begin
      n_err++; $display("FAIL boot_cycle: obs=%h required=%h state=%0d", obs, exp, state);
    end
    for (int k = 0; k < WORDS; k++) begin
      step();
      exp = pack(1'b1, 5'(k), 16'hA000 + 16'(k), 1'b0, (k == WORDS - 1), 1'b1, 1'b1);
      n_vec++;
      if (obs !== exp) begin
        n_err++; $display("FAIL boot_copy[%0d]: obs=%h required=%h", k, obs, exp);
      end
    end
    step();
    exp = pack(1'b0, 5'd0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (obs !== exp || state !== ST_RUN) begin
      n_err++; $display("FAIL boot_to_run: obs=%h required=%h state=%0d", obs, exp, state);
    end
  endtask

  task automatic test_user_write();
    logic [25:0] exp;
    bus.i_user_wr_req = 1'b1; bus.i_user_addr = 5'd5; bus.i_user_data = 16'h1234;
    step();
    bus.i_user_wr_req = 1'b0;
    exp = pack(1'b1, 5'd5, 16'h1234, 1'b1, 1'b0, 1'b1, 1'b0);
    n_vec++;
    if (obs !== exp || state !== ST_USER) begin
      n_err++; $display("FAIL user_write: obs=%h required=%h state=%0d", obs, exp, state);
    end
    step();
    exp = pack(1'b0, 5'd0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (obs !== exp || state !== ST_RUN) begin
      n_err++; $display("FAIL user_return: obs=%h required=%h state=%0d", obs, exp, state);
    end
  endtask

  task automatic test_reload_priority();
    logic [25:0] exp;
    bus.i_reload = 1'b1; bus.i_user_wr_req = 1'b1;
    bus.i_user_addr = 5'd9; bus.i_user_data = 16'hBEEF;
    step();
    bus.i_reload = 1'b0;
    exp = pack(1'b0, 5'd0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    n_vec++;
    if (obs !== exp || state !== ST_BOOT) begin
      n_err++; $display("FAIL prio_boot: obs=%h required=%h state=%0d", obs, exp, state);
    end
    for (int k = 0; k < WORDS; k++) begin
      step();
      exp = pack(1'b1, 5'(k), 16'hA000 + 16'(k), 1'b0, (k == WORDS - 1), 1'b1, 1'b1);
      n_vec++;
      if (obs !== exp) begin
        n_err++; $display("FAIL prio_copy[%0d]: obs=%h required=%h", k, obs, exp);
      end
    end
    step();
    exp = pack(1'b0, 5'd0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (obs !== exp || state !== ST_RUN) begin
      n_err++; $display("FAIL prio_run: obs=%h required=%h state=%0d", obs, exp, state);
    end
    step();
    bus.i_user_wr_req = 1'b0;
    exp = pack(1'b1, 5'd9, 16'hBEEF, 1'b1, 1'b0, 1'b1, 1'b0);
    n_vec++;
    if (obs !== exp) begin
      n_err++; $display("FAIL prio_grant: obs=%h required=%h", obs, exp);
    end
    step();
  endtask

  task automatic test_reload_in_load();
    logic [25:0] exp;
    bus.i_reload = 1'b1;
    step();
    bus.i_reload = 1'b0;
    repeat (21) step();
    exp = pack(1'b1, 5'd20, 16'hA014, 1'b0, 1'b0, 1'b1, 1'b1);
    n_vec++;
    if (obs !== exp) begin
      n_err++; $display("FAIL reload_at20: obs=%h required=%h", obs, exp);
    end
    bus.i_reload = 1'b1;
    step();
    bus.i_reload = 1'b0;
    for (int k = 0; k < WORDS; k++) begin
      if (k > 0) step();
      exp = pack(1'b1, 5'(k), 16'hA000 + 16'(k), 1'b0, (k == WORDS - 1), 1'b1, 1'b1);
      n_vec++;
      if (obs !== exp) begin
        n_err++; $display("FAIL reload_copy[%0d]: obs=%h required=%h", k, obs, exp);
      end
    end
    step();
    n_vec++;
    if (state !== ST_RUN || bus.o_cpu_hold !== 1'b0) begin
      n_err++; $display("FAIL reload_run: state=%0d hold=%b required RUN/0", state, bus.o_cpu_hold);
    end
  endtask

  task automatic test_reset_mid_load();
    logic [25:0] exp;
    bus.i_reload = 1'b1;
    step();
    bus.i_reload = 1'b0;
    repeat (11) step();
    exp = pack(1'b1, 5'd10, 16'hA00A, 1'b0, 1'b0, 1'b1, 1'b1);
    n_vec++;
    if (obs !== exp) begin
      n_err++; $display("FAIL rstload_at10: obs=%h required=%h", obs, exp);
    end
    #2 rst = 1'b1;
    #1;
    exp = pack(1'b0, 5'd0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    n_vec++;
    if (obs !== exp || state !== ST_BOOT || bus.o_bios_addr !== 5'd0) begin
      n_err++; $display("FAIL rstload_async: obs=%h required=%h state=%0d", obs, exp, state);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step();
    exp = pack(1'b1, 5'd0, 16'hA000, 1'b0, 1'b0, 1'b1, 1'b1);
    n_vec++;
    if (obs !== exp) begin
      n_err++; $display("FAIL rstload_restart: obs=%h required=%h", obs, exp);
    end
    wait_run("rstload");
  endtask

  task automatic test_back_to_back();
    logic [25:0] exp;
    logic [4:0]  a;
    logic [15:0] d;
    logic [4:0]  lat_a;
    logic [15:0] lat_d;
    lat_a = '0; lat_d = '0;
    bus.i_user_wr_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a = 5'(i * 3 + 1);
      d = 16'hC000 + 16'(i);
      bus.i_user_addr = a; bus.i_user_data = d;
      if (i % 2 == 0) begin
        lat_a = a; lat_d = d;
      end
      step();
      if (i % 2 == 0) exp = pack(1'b1, lat_a, lat_d, 1'b1, 1'b0, 1'b1, 1'b0);
      else            exp = pack(1'b0, 5'd0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      n_vec++;
      if (obs !== exp) begin
        n_err++; $display("FAIL b2b[%0d]: obs=%h required=%h", i, obs, exp);
      end
    end
    step();
    bus.i_user_wr_req = 1'b0;
    bus.i_reload = 1'b1;
    n_vec++;
    if (state !== ST_USER) begin
      n_err++; $display("FAIL b2b_user: state=%0d required USER", state);
    end
    step();
    n_vec++;
    if (state !== ST_RUN) begin
      n_err++; $display("FAIL user_ignores_reload: state=%0d required RUN", state);
    end
    step();
    bus.i_reload = 1'b0;
    n_vec++;
    if (state !== ST_BOOT) begin
      n_err++; $display("FAIL run_takes_reload: state=%0d required BOOT", state);
    end
    wait_run("b2b");
  endtask

  initial begin
    test_reset();
    test_boot_copy();
    test_user_write();
    test_reload_priority();
    test_reload_in_load();
    test_reset_mid_load();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
